// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - op/state encodings, lane constants and address helpers for mem_access_seq
package mem_seq_pkg;

    localparam logic [2:0] MEM_OP_LW  = 3'd0;
    localparam logic [2:0] MEM_OP_LB  = 3'd1;
    localparam logic [2:0] MEM_OP_LBU = 3'd2;
    localparam logic [2:0] MEM_OP_LH  = 3'd3;
    localparam logic [2:0] MEM_OP_LHU = 3'd4;
    localparam logic [2:0] MEM_OP_SW  = 3'd5;
    localparam logic [2:0] MEM_OP_SB  = 3'd6;
    localparam logic [2:0] MEM_OP_SH  = 3'd7;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // Loads occupy the low encodings, so a single compare classifies them.
    function automatic logic is_load(input logic [2:0] op);
        return op <= MEM_OP_LHU;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEM_OP_LW, MEM_OP_SW:                 return lo != 2'b00;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:     return lo[0];
            default:                              return 1'b0;
        endcase
    endfunction

    // Lane actually used for the access: bits below the access size are dropped.
    function automatic logic [1:0] force_lane(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEM_OP_LW, MEM_OP_SW:                 return 2'b00;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:     return {lo[1], 1'b0};
            default:                              return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_ld_st_align.sv
// rtl/mem_access_seq_ld_st_align.sv - load extraction/extension and store lane merge (combinational)
// Ports: ld_word (read word) -> ld_val (extended load value);
//        old_word + wdata -> st_word (merged store word); lane = addr[1:0], op = access op.
module ld_st_align
    import mem_seq_pkg::*;
(
    input  logic [WORD_W-1:0] ld_word,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        lane,
    input  logic [2:0]        op,
    output logic [WORD_W-1:0] ld_val,
    output logic [WORD_W-1:0] st_word
);

    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;

    always_comb begin
        case (lane)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];

        case (op)
            MEM_OP_LB:  ld_val = {{(WORD_W-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
            MEM_OP_LBU: ld_val = {{(WORD_W-BYTE_W){1'b0}}, ld_byte};
            MEM_OP_LH:  ld_val = {{(WORD_W-HALF_W){ld_half[HALF_W-1]}}, ld_half};
            MEM_OP_LHU: ld_val = {{(WORD_W-HALF_W){1'b0}}, ld_half};
            default:    ld_val = ld_word;
        endcase
    end

    always_comb begin
        st_word = old_word;
        case (op)
            MEM_OP_SB: begin
                case (lane)
                    2'd0:    st_word[7:0]   = wdata[7:0];
                    2'd1:    st_word[15:8]  = wdata[7:0];
                    2'd2:    st_word[23:16] = wdata[7:0];
                    default: st_word[31:24] = wdata[7:0];
                endcase
            end
            MEM_OP_SH: begin
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - word-memory access sequencer for LW/LB/LBU/LH/LHU/SW/SB/SH with RMW sub-word stores
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses respond with resp_err, no memory cycle).
// Ports: clk, rst (sync active-low); req_valid/req_ready/req_op/req_addr/req_wdata (request);
//        resp_valid/resp_rdata/resp_err (one-cycle response); busy;
//        mem_en/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack (word-wide data RAM).
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;   // read word for RMW, or final load result
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] st_word;
    logic              accept;
    logic              trap;

    assign accept = req_valid && (state == S_IDLE);

`ifdef MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_op, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    ld_st_align u_align (
        .ld_word  (mem_rdata),
        .old_word (word_q),
        .wdata    (wdata_q),
        .lane     (lane_q),
        .op       (op_q),
        .ld_val   (ld_val),
        .st_word  (st_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            word_q    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        lane_q  <= force_lane(req_op, req_addr[1:0]);
                        wdata_q <= req_wdata;
                        word_q  <= '0;
                        if (trap) begin
                            state <= S_RESP;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (req_op == MEM_OP_SW) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                                state     <= S_WR;
                            end else begin
                                mem_we <= 1'b0;
                                state  <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        mem_en <= 1'b0;
                        if (is_load(op_q)) begin
                            word_q <= ld_val;
                            state  <= S_RESP;
                        end else begin
                            word_q <= mem_rdata;
                            state  <= S_MERGE;
                        end
                    end
                end
                S_MERGE: begin
                    // Merged word is registered here so the write phase presents a stable value.
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= st_word;
                    state     <= S_WR;
                end
                S_WR: begin
                    if (mem_ack) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        word_q <= '0;
                        state  <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst)        err_q <= 1'b0;
        else if (accept) err_q <= trap;
    end

    assign resp_err = err_q && (state == S_RESP);
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready  = (state == S_IDLE);
    assign busy       = ~req_ready;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = resp_valid ? word_q : '0;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - scoreboard bench for mem_access_seq
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_access_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] mem_arr [0:15];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic stray_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event want none", name);
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    flag("unexpected_resp");
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    chk("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    // Memory model: acks after ack_delay wait cycles, checks every write cycle against the head entry
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (rst === 1'b1 && mem_en === 1'b1) begin
                if (mem_we) begin
                    if (wa_q.size() == 0) begin
                        flag("unexpected_write");
                    end else begin
                        chk("wr_addr", mem_addr, wa_q[0]);
                        chk("wr_data", mem_wdata, wd_q[0]);
                    end
                end
                if (wait_cnt == ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem_arr[mem_addr[5:2]] = mem_wdata;
                        if (wa_q.size() != 0) begin
                            void'(wa_q.pop_front());
                            void'(wd_q.pop_front());
                        end
                    end else begin
                        mem_rdata = mem_arr[mem_addr[5:2]];
                        if (rd_q.size() == 0) flag("unexpected_read");
                        else chk("rd_addr", mem_addr, rd_q.pop_front());
                    end
                end else begin
                    wait_cnt++;
                    mem_rdata = 32'h5A5A_5A5A;
                end
            end else begin
                wait_cnt = 0;
                mem_ack  = stray_ack;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                         input logic has_rd, input logic [31:0] rd_addr,
                         input logic has_wr, input logic [31:0] wr_addr, input logic [31:0] wr_data);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = cyc;
        sb_q.push_back(e);
        if (has_rd) rd_q.push_back(rd_addr);
        if (has_wr) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
        // Scramble the request bus to show it is latched at accept
        req_valid = 1'b0;
        req_op    = 3'd5;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            flag("resp_timeout");
            sb_q.delete();
        end
        chk("pending_reads", rd_q.size(), 0);
        chk("pending_writes", wa_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem_arr[i] = 32'h0;
        mem_arr[4] = 32'h8899_AABB;
        mem_arr[8] = 32'h1122_3344;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;

        // Loads from 0x8899AABB
        issue(3'd1, 32'h11, 0, 32'hFFFF_FFAA, 0, 2, 1, 32'h10, 0, 0, 0);
        issue(3'd2, 32'h11, 0, 32'h0000_00AA, 0, 2, 1, 32'h10, 0, 0, 0);
        issue(3'd3, 32'h12, 0, 32'hFFFF_8899, 0, 2, 1, 32'h10, 0, 0, 0);
        issue(3'd4, 32'h12, 0, 32'h0000_8899, 0, 2, 1, 32'h10, 0, 0, 0);
        issue(3'd0, 32'h10, 0, 32'h8899_AABB, 0, 2, 1, 32'h10, 0, 0, 0);
        issue(3'd1, 32'h10, 0, 32'hFFFF_FFBB, 0, 2, 1, 32'h10, 0, 0, 0);

        // RMW stores: only the low byte/half of wdata is used
        issue(3'd6, 32'h13, 32'hABCD_EF12, 32'h0, 0, 4, 1, 32'h10, 1, 32'h10, 32'h1299_AABB);
        issue(3'd7, 32'h10, 32'hFFFF_3456, 32'h0, 0, 4, 1, 32'h10, 1, 32'h10, 32'h1299_3456);
        issue(3'd0, 32'h10, 0, 32'h1299_3456, 0, 2, 1, 32'h10, 0, 0, 0);

        // SW with three wait cycles: write held stable, no read
        ack_delay = 3;
        issue(3'd5, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 5, 0, 0, 1, 32'h20, 32'hDEAD_BEEF);
        ack_delay = 0;

        // Stray mem_ack in IDLE
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_req_ready", {31'd0, req_ready}, 32'd1);
            chk("stray_mem_en", {31'd0, mem_en}, 32'd0);
        end
        stray_ack = 1'b0;

        // Reset during MERGE of an SB: read happens, write must not
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = 3'd6;
        req_addr  = 32'h10;
        req_wdata = 32'h77;
        rd_q.push_back(32'h10);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("merge_mem_en", {31'd0, mem_en}, 32'd0);
        chk("merge_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_reads", rd_q.size(), 0);
        issue(3'd0, 32'h10, 0, 32'h1299_3456, 0, 2, 1, 32'h10, 0, 0, 0);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        issue(3'd0, 32'h22, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        issue(3'd3, 32'h13, 0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
`else
        issue(3'd0, 32'h22, 0, 32'hDEAD_BEEF, 0, 2, 1, 32'h20, 0, 0, 0);
        issue(3'd3, 32'h13, 0, 32'h0000_1299, 0, 2, 1, 32'h10, 0, 0, 0);
`endif
        issue(3'd1, 32'h23, 0, 32'hFFFF_FFDE, 0, 2, 1, 32'h20, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
